// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks the ADV7513 init table and issues one 3-byte
// I2C write per entry, with NACK/timeout retry and hot-plug reruns.
module i2c_init_sequencer #(
    parameter logic [7:0] SLAVE_ADDR    = 8'h72,
    parameter int         NUM_REGS      = 12,
    parameter int         MAX_RETRIES   = 3,
    parameter int         STARTUP_DELAY = 20000,
    parameter int         TIMEOUT       = 255,
    parameter int         RETRY_GAP     = 2
) (
    input  logic        clock_100khz,
    input  logic        reset,
    input  logic        init_request,
    input  logic        hpd,
    input  logic        stop,
    input  logic        ack,
    output logic        start,
    output logic [7:0]  slave_address,
    output logic [15:0] register_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  error_index
);

    localparam int CMAX0 = (STARTUP_DELAY > TIMEOUT) ? STARTUP_DELAY : TIMEOUT;
    localparam int CMAX  = (CMAX0 > RETRY_GAP) ? CMAX0 : RETRY_GAP;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int TW    = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_DELAY - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT);
    localparam logic [CW-1:0] GAP_LAST     = CW'(RETRY_GAP - 1);
    localparam logic [3:0]    LAST_IDX     = 4'(NUM_REGS - 1);
    localparam logic [TW-1:0] TRIES_MAX    = TW'(MAX_RETRIES);

    typedef enum logic [3:0] {
        S_STARTUP,
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_FAIL,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [TW-1:0] tries;
    logic          nack_seen;
    logic          pending;
    logic          hpd_meta;
    logic          hpd_sync;
    logic          hpd_prev;
    logic          hpd_rise;
    logic          rerun;

    logic cnt_clr;
    logic idx_clr;
    logic idx_inc;
    logic tries_clr;
    logic tries_inc;
    logic pend_clr;
    logic clr_flags;

    function automatic logic [15:0] table_entry(input logic [3:0] i);
        case (i)
            4'd0:    table_entry = 16'h4110;
            4'd1:    table_entry = 16'h9803;
            4'd2:    table_entry = 16'h9AE0;
            4'd3:    table_entry = 16'h9C30;
            4'd4:    table_entry = 16'h9D61;
            4'd5:    table_entry = 16'hA2A4;
            4'd6:    table_entry = 16'hA3A4;
            4'd7:    table_entry = 16'hE0D0;
            4'd8:    table_entry = 16'hF900;
            4'd9:    table_entry = 16'h1500;
            4'd10:   table_entry = 16'h1630;
            4'd11:   table_entry = 16'hAF06;
            default: table_entry = 16'h0000;
        endcase
    endfunction

    assign slave_address = SLAVE_ADDR;
    assign hpd_rise      = hpd_sync & ~hpd_prev;
    assign rerun         = pending | hpd_rise;

    always_ff @(posedge clock_100khz) begin
        if (reset) begin
            hpd_meta <= 1'b0;
            hpd_sync <= 1'b0;
            hpd_prev <= 1'b0;
        end else begin
            hpd_meta <= hpd;
            hpd_sync <= hpd_meta;
            hpd_prev <= hpd_sync;
        end
    end

    always_ff @(posedge clock_100khz) begin
        if (reset) begin
            state <= S_STARTUP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        tries_clr  = 1'b0;
        tries_inc  = 1'b0;
        pend_clr   = 1'b0;
        clr_flags  = 1'b0;
        unique case (state)
            S_STARTUP: begin
                if (cnt == STARTUP_LAST) begin
                    state_next = S_LOAD;
                    idx_clr    = 1'b1;
                    tries_clr  = 1'b1;
                    pend_clr   = 1'b1;
                end
            end
            S_IDLE: begin
                if (init_request || rerun) begin
                    state_next = S_LOAD;
                    idx_clr    = 1'b1;
                    tries_clr  = 1'b1;
                    pend_clr   = 1'b1;
                    clr_flags  = 1'b1;
                end
            end
            S_LOAD: begin
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                state_next = S_WAIT;
                cnt_clr    = 1'b1;
            end
            S_WAIT: begin
                if (!stop) begin
                    state_next = S_CHECK;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = S_FAIL;
                end
            end
            S_CHECK: begin
                if (rerun) begin
                    state_next = S_LOAD;
                    idx_clr    = 1'b1;
                    tries_clr  = 1'b1;
                    pend_clr   = 1'b1;
                end else if (nack_seen) begin
                    state_next = S_FAIL;
                end else if (idx == LAST_IDX) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_LOAD;
                    idx_inc    = 1'b1;
                    tries_clr  = 1'b1;
                end
            end
            S_FAIL: begin
                // a pending hot-plug abandons retries and restarts cleanly
                if (rerun) begin
                    state_next = S_LOAD;
                    idx_clr    = 1'b1;
                    tries_clr  = 1'b1;
                    pend_clr   = 1'b1;
                end else if (tries == TRIES_MAX) begin
                    state_next = S_ERROR;
                end else begin
                    tries_inc  = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = (RETRY_GAP == 0) ? S_LOAD : S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = S_LOAD;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            S_ERROR: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100khz) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= '0;
            tries     <= '0;
            nack_seen <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state == S_STARTUP || state == S_WAIT || state == S_GAP) begin
                cnt <= cnt + 1'b1;
            end

            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 4'd1;
            end

            if (tries_clr) begin
                tries <= '0;
            end else if (tries_inc) begin
                tries <= tries + 1'b1;
            end

            if (state == S_LOAD) begin
                nack_seen <= 1'b0;
            end else if (state == S_WAIT) begin
                nack_seen <= nack_seen | ack;
            end

            if (pend_clr) begin
                pending <= 1'b0;
            end else if (hpd_rise) begin
                pending <= 1'b1;
            end
        end
    end

    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clock_100khz) begin
        if (reset) begin
            start         <= 1'b0;
            register_data <= 16'h0000;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            error_index   <= 4'd0;
        end else begin
            start <= (state_next == S_ISSUE);
            busy  <= !(state_next inside {S_IDLE, S_DONE, S_ERROR});

            if (state == S_LOAD) begin
                register_data <= table_entry(idx);
            end

            if (clr_flags) begin
                done <= 1'b0;
            end else if (state_next == S_DONE) begin
                done <= 1'b1;
            end

            if (clr_flags) begin
                error <= 1'b0;
            end else if (state_next == S_ERROR) begin
                error       <= 1'b1;
                error_index <= idx;
            end
        end
    end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: randomized controller model plus a table-level
// reference of which writes each run must issue and how it must end.
module tb_i2c_init_sequencer;

    localparam int NREG = 12;
    localparam int MAXR = 3;
    localparam int TMO  = 255;
    localparam int SDLY = 16;
    localparam logic [7:0] SLV = 8'h72;
    localparam logic [15:0] TBL [12] = '{
        16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
        16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'hAF06
    };

    logic        clk;
    logic        reset;
    logic        init_request;
    logic        hpd;
    logic        stop;
    logic        ack;
    logic        start;
    logic [7:0]  slave_address;
    logic [15:0] register_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  error_index;

    int n_cmp;
    int n_bad;
    int cyc;
    int rel_cyc;
    int last_stop;
    int gap_err;
    int addr_err;
    bit never_stop;
    int plan [12];
    int nack_left [12];
    logic [15:0] obs_q [$];
    int st_cyc [$];
    logic [15:0] exp_q [$];
    bit exp_err;
    int exp_idx;

    i2c_init_sequencer #(
        .SLAVE_ADDR(SLV),
        .NUM_REGS(NREG),
        .MAX_RETRIES(MAXR),
        .STARTUP_DELAY(SDLY),
        .TIMEOUT(TMO),
        .RETRY_GAP(2)
    ) dut (
        .clock_100khz(clk),
        .reset(reset),
        .init_request(init_request),
        .hpd(hpd),
        .stop(stop),
        .ack(ack),
        .start(start),
        .slave_address(slave_address),
        .register_data(register_data),
        .busy(busy),
        .done(done),
        .error(error),
        .error_index(error_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int index_of(input logic [15:0] d);
        for (int i = 0; i < NREG; i++) begin
            if (TBL[i] == d) return i;
        end
        return -1;
    endfunction

    // each entry is tried until it ACKs, at most MAXR+1 times
    function automatic void model_run();
        exp_q.delete();
        exp_err = 1'b0;
        exp_idx = 0;
        for (int e = 0; e < NREG; e++) begin
            int n;
            n = (plan[e] > MAXR) ? MAXR + 1 : plan[e] + 1;
            for (int k = 0; k < n; k++) exp_q.push_back(TBL[e]);
            if (plan[e] > MAXR) begin
                exp_err = 1'b1;
                exp_idx = e;
                break;
            end
        end
    endfunction

    always begin : ctrl_model
        int lat;
        int e;
        logic nk;
        @(negedge clk);
        if (start === 1'b1 && reset === 1'b0) begin
            obs_q.push_back(register_data);
            st_cyc.push_back(cyc);
            if (cyc - last_stop < 2) gap_err++;
            if (slave_address !== SLV) addr_err++;
            if (!never_stop) begin
                e = index_of(register_data);
                nk = 1'b0;
                if (e >= 0) begin
                    nk = (nack_left[e] > 0);
                    if (nk) nack_left[e]--;
                end
                lat = $urandom_range(2, 9);
                repeat (lat - 1) begin
                    @(negedge clk);
                    if (start === 1'b1) gap_err++;
                end
                ack = nk;
                @(negedge clk);
                ack = 1'b0;
                stop = 1'b0;
                last_stop = cyc + 1;
                @(negedge clk);
                stop = 1'b1;
            end
        end
    end

    task automatic begin_run();
        nack_left = plan;
        obs_q.delete();
        st_cyc.delete();
        gap_err = 0;
        addr_err = 0;
        model_run();
    endtask

    task automatic pulse_init();
        @(negedge clk);
        init_request = 1'b1;
        @(negedge clk);
        init_request = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int e = 0; e < NREG; e++) plan[e] = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (start !== 1'b0) begin
            n_bad++; $display("FAIL reset_start: got %b want 0", start);
        end
        n_cmp++;
        if (slave_address !== SLV) begin
            n_bad++; $display("FAIL reset_addr: got %h want %h", slave_address, SLV);
        end
        n_cmp++;
        if (register_data !== 16'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0000", register_data);
        end
        n_cmp++;
        if ({busy, done, error} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, error});
        end
        n_cmp++;
        if (error_index !== 4'd0) begin
            n_bad++; $display("FAIL reset_eidx: got %0d want 0", error_index);
        end
        begin_run();
        rel_cyc = cyc;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || start !== 1'b0) begin
            n_bad++; $display("FAIL startup_busy: got busy=%b start=%b want 1 0", busy, start);
        end
    endtask

    task automatic test_all_ack();
        bit ok;
        wait_end(3000, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL all_ack_end: got timeout want done");
        end
        n_cmp++;
        if (st_cyc.size() == 0 || st_cyc[0] - rel_cyc < SDLY) begin
            n_bad++; $display("FAIL startup_delay: got %0d starts early want >= %0d clocks", st_cyc.size(), SDLY);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL all_ack_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL all_ack_data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if ({done, error, busy} !== 3'b100) begin
            n_bad++; $display("FAIL all_ack_flags: got %b want 100", {done, error, busy});
        end
        n_cmp++;
        if (gap_err != 0 || addr_err != 0) begin
            n_bad++; $display("FAIL all_ack_proto: got gap=%0d addr=%0d want 0 0", gap_err, addr_err);
        end
    endtask

    task automatic test_nack_retry();
        bit ok;
        int n3;
        for (int e = 0; e < NREG; e++) plan[e] = 0;
        plan[3] = 2;
        begin_run();
        pulse_init();
        wait_end(3000, ok);
        n3 = 0;
        foreach (obs_q[i]) if (obs_q[i] == 16'h9C30) n3++;
        n_cmp++;
        if (!ok || n3 != 3) begin
            n_bad++; $display("FAIL nack_retry_count: got ok=%0d n=%0d want 1 3", ok, n3);
        end
        n_cmp++;
        if (obs_q != exp_q) begin
            n_bad++; $display("FAIL nack_retry_seq: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        n_cmp++;
        if ({done, error} !== 2'b10) begin
            n_bad++; $display("FAIL nack_retry_flags: got %b want 10", {done, error});
        end
    endtask

    task automatic test_nack_exhaust();
        bit ok;
        for (int e = 0; e < NREG; e++) plan[e] = 0;
        plan[5] = 99;
        begin_run();
        pulse_init();
        wait_end(3000, ok);
        repeat (300) @(negedge clk);
        n_cmp++;
        if (!ok || obs_q != exp_q) begin
            n_bad++; $display("FAIL exhaust_seq: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        n_cmp++;
        if ({done, error, busy} !== 3'b010 || error_index !== 4'(exp_idx)) begin
            n_bad++; $display("FAIL exhaust_flags: got %b idx %0d want 010 idx %0d", {done, error, busy}, error_index, exp_idx);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        for (int e = 0; e < NREG; e++) plan[e] = 0;
        begin_run();
        never_stop = 1'b1;
        pulse_init();
        wait_end(3000, ok);
        never_stop = 1'b0;
        n_cmp++;
        if (!ok || obs_q.size() != MAXR + 1) begin
            n_bad++; $display("FAIL timeout_count: got %0d want %0d", obs_q.size(), MAXR + 1);
        end
        for (int i = 0; i + 1 < st_cyc.size(); i++) begin
            n_cmp++;
            if (st_cyc[i+1] - st_cyc[i] != TMO + 6 || obs_q[i+1] !== 16'h4110) begin
                n_bad++; $display("FAIL timeout_spacing[%0d]: got %0d want %0d", i, st_cyc[i+1] - st_cyc[i], TMO + 6);
            end
        end
        n_cmp++;
        if ({done, error} !== 2'b01 || error_index !== 4'd0) begin
            n_bad++; $display("FAIL timeout_flags: got %b idx %0d want 01 idx 0", {done, error}, error_index);
        end
    endtask

    task automatic test_hpd_restart();
        bit ok;
        bit seen;
        for (int e = 0; e < NREG; e++) plan[e] = 0;
        begin_run();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(TBL[i]);
        for (int i = 0; i < NREG; i++) exp_q.push_back(TBL[i]);
        pulse_init();
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = (obs_q.size() >= 8);
        end
        hpd = 1'b1;
        wait_end(5000, ok);
        n_cmp++;
        if (!seen || !ok || obs_q.size() != 20) begin
            n_bad++; $display("FAIL hpd_count: got %0d want 20", obs_q.size());
        end
        n_cmp++;
        if (obs_q != exp_q) begin
            n_bad++; $display("FAIL hpd_seq: got order differs, want 8 then full table");
        end
        n_cmp++;
        if ({done, error} !== 2'b10) begin
            n_bad++; $display("FAIL hpd_flags: got %b want 10", {done, error});
        end
        hpd = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_same_clock();
        bit ok;
        for (int e = 0; e < NREG; e++) plan[e] = 0;
        begin_run();
        @(negedge clk);
        hpd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        init_request = 1'b1;
        @(negedge clk);
        init_request = 1'b0;
        wait_end(3000, ok);
        repeat (100) @(negedge clk);
        n_cmp++;
        if (!ok || obs_q != exp_q) begin
            n_bad++; $display("FAIL same_clock_seq: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        hpd = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int r = 0; r < 4; r++) begin
            for (int e = 0; e < NREG; e++) begin
                int v;
                v = $urandom_range(0, 19);
                plan[e] = (v < 13) ? 0 : v - 13;
            end
            begin_run();
            pulse_init();
            if (r == 1) begin
                for (int i = 0; i < 500 && obs_q.size() < 3; i++) @(negedge clk);
                if (busy === 1'b1) pulse_init();
            end
            wait_end(20000, ok);
            repeat (20) @(negedge clk);
            n_cmp++;
            if (!ok || obs_q != exp_q) begin
                n_bad++; $display("FAIL b2b_seq[%0d]: got %0d writes want %0d", r, obs_q.size(), exp_q.size());
            end
            n_cmp++;
            if (done !== !exp_err || error !== exp_err || (exp_err && error_index !== 4'(exp_idx))) begin
                n_bad++; $display("FAIL b2b_flags[%0d]: got d=%b e=%b idx=%0d want e=%0d idx=%0d", r, done, error, error_index, exp_err, exp_idx);
            end
            n_cmp++;
            if (gap_err != 0) begin
                n_bad++; $display("FAIL b2b_gap[%0d]: got %0d want 0", r, gap_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int e = 0; e < NREG; e++) plan[e] = 0;
        begin_run();
        never_stop = 1'b1;
        pulse_init();
        for (int i = 0; i < 100 && obs_q.size() < 1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({start, busy, done, error} !== 4'b0000 || register_data !== 16'h0) begin
            n_bad++; $display("FAIL reset_mid: got s/b/d/e=%b data=%h want 0000 0000", {start, busy, done, error}, register_data);
        end
        @(negedge clk);
        never_stop = 1'b0;
        begin_run();
        rel_cyc = cyc;
        reset = 1'b0;
        wait_end(3000, ok);
        n_cmp++;
        if (!ok || obs_q != exp_q) begin
            n_bad++; $display("FAIL reset_restart_seq: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        n_cmp++;
        if (st_cyc.size() == 0 || st_cyc[0] - rel_cyc < SDLY || done !== 1'b1) begin
            n_bad++; $display("FAIL reset_restart_delay: got done=%b want delayed restart done=1", done);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        last_stop = -100;
        never_stop = 1'b0;
        reset = 1'b1;
        init_request = 1'b0;
        hpd = 1'b0;
        stop = 1'b1;
        ack = 1'b0;
        test_reset();
        test_all_ack();
        test_nack_retry();
        test_nack_exhaust();
        test_timeout();
        test_hpd_restart();
        test_same_clock();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
